// File: rtl/press_classifier_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : press_classifier_pkg
//  Description : Shared definitions for the button press classifier: the
//                3-bit FSM state encodings, the default timing thresholds
//                (also used by the debouncer top) and a helper that derives
//                the internal counter width from those thresholds.
//  Revision    : 1.0 - initial release
// ============================================================================
package press_classifier_pkg;

    // FSM state encodings
    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_PRESSED   = 3'd1;
    localparam logic [2:0] c_LONG_HELD = 3'd2;
    localparam logic [2:0] c_WAIT_GAP  = 3'd3;
    localparam logic [2:0] c_SECOND    = 3'd4;

    // Default thresholds, in clk cycles
    localparam int c_DEF_LONG_CYCLES = 50_000_000;
    localparam int c_DEF_GAP_CYCLES  = 15_000_000;

    // One bit per user event produced by the classifier
    typedef struct packed {
        logic press;
        logic release_ev;
        logic short_ev;
        logic long_ev;
        logic double_ev;
    } pulses_t;

    // Counter must be able to hold the larger threshold value.
    function automatic int cnt_width(input int long_cycles, input int gap_cycles);
        int max_v;
        max_v = (long_cycles > gap_cycles) ? long_cycles : gap_cycles;
        return $clog2(max_v + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/press_classifier_event_timer.sv
`default_nettype none
// ============================================================================
//  Module      : event_timer
//  Description : Free-running cycle counter used by press_classifier to time
//                hold and gap durations. Threshold compares live in the
//                parent; this block only counts.
//  Ports       : clk   - system clock, rising edge
//                rst   - asynchronous active-high reset
//                clr   - synchronous clear (wins over en)
//                en    - count enable
//                count - current count value
//  Revision    : 1.0 - initial release
// ============================================================================
module event_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/press_classifier.sv
`default_nettype none
// ============================================================================
//  Module      : press_classifier
//  Description : Turns the debounced button level into one-cycle user
//                events: press, release, short press, long press and
//                double click. All outputs are registered.
//  Ports       : clk           - system clock, rising edge
//                rst           - asynchronous active-high reset
//                db_in         - debounced button level (synchronous to clk)
//                press_pulse   - pulse on each accepted press
//                release_pulse - pulse on each release
//                short_press   - pulse when a single short press completes
//                long_press    - pulse once the button has been held long
//                double_click  - pulse on the second press of a double click
//                busy          - high while the FSM is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int LONG_CYCLES = c_DEF_LONG_CYCLES,
    parameter int GAP_CYCLES  = c_DEF_GAP_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic db_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);

    localparam int CNT_W = cnt_width(LONG_CYCLES, GAP_CYCLES);

    // Last count value before each threshold fires (counter starts at 0 on entry).
    localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    pulses_t          w_ev;
    logic [CNT_W-1:0] w_count;
    logic             w_clr;
    logic             w_en;

    // ------------------------------------------------------------------
    // Transition logic. Input edges are tested before counter thresholds,
    // so an edge always wins when both happen in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        w_ev   = '0;
        case (r_state)
            c_IDLE: begin
                if (db_in) begin
                    w_next   = c_PRESSED;
                    w_ev.press = 1'b1;
                end
            end
            c_PRESSED: begin
                if (!db_in) begin
                    w_next          = c_WAIT_GAP;
                    w_ev.release_ev = 1'b1;
                end else if (w_count == c_LONG_LAST) begin
                    w_next       = c_LONG_HELD;
                    w_ev.long_ev = 1'b1;
                end
            end
            c_LONG_HELD: begin
                // A long press never opens a double-click window.
                if (!db_in) begin
                    w_next          = c_IDLE;
                    w_ev.release_ev = 1'b1;
                end
            end
            c_WAIT_GAP: begin
                if (db_in) begin
                    w_next         = c_SECOND;
                    w_ev.press     = 1'b1;
                    w_ev.double_ev = 1'b1;
                end else if (w_count == c_GAP_LAST) begin
                    w_next        = c_IDLE;
                    w_ev.short_ev = 1'b1;
                end
            end
            c_SECOND: begin
                if (!db_in) begin
                    w_next          = c_IDLE;
                    w_ev.release_ev = 1'b1;
                end
            end
            default: begin
                // Unreachable encodings recover silently.
                w_next = c_IDLE;
            end
        endcase
    end

    // Counter restarts on every state change and only runs in timed states.
    assign w_clr = (w_next != r_state);
    assign w_en  = (r_state == c_PRESSED) || (r_state == c_WAIT_GAP);

    event_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_clr),
        .en    (w_en),
        .count (w_count)
    );

    // Next-state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Output register: pulses are high for exactly the cycle after the
    // transition that produced them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_press   <= 1'b0;
            long_press    <= 1'b0;
            double_click  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            press_pulse   <= w_ev.press;
            release_pulse <= w_ev.release_ev;
            short_press   <= w_ev.short_ev;
            long_press    <= w_ev.long_ev;
            double_click  <= w_ev.double_ev;
            busy          <= (w_next != c_IDLE);
        end
    end

endmodule
`default_nettype wire
